// File: rtl/mem_arbiter.sv
// Arbitrates one single-port synchronous-read memory between the fetch and load/store ports.
// Define ARB_ROUND_ROBIN_EN to alternate grants on contention; otherwise data has fixed priority.
module mem_arbiter #(
  parameter int MEM_WORDS_LOG2 = 8,
  parameter int WAIT_STATES    = 0
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      i_req,
  input  logic [31:0]               i_addr,
  output logic [31:0]               i_rdata,
  output logic                      i_ack,
  input  logic                      d_req,
  input  logic                      d_we,
  input  logic [3:0]                d_wmask,
  input  logic [31:0]               d_addr,
  input  logic [31:0]               d_wdata,
  output logic [31:0]               d_rdata,
  output logic                      d_ack,
  output logic                      m_en,
  output logic [MEM_WORDS_LOG2-1:0] m_addr,
  output logic [3:0]                m_wmask,
  output logic [31:0]               m_wdata,
  input  logic [31:0]               m_rdata,
  output logic                      busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                    state_q, state_d;
  logic                      gnt_data_q, gnt_data_d;
  logic [MEM_WORDS_LOG2-1:0] addr_q, addr_d;
  logic                      we_q, we_d;
  logic [3:0]                wmask_q, wmask_d;
  logic [31:0]               wdata_q, wdata_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [31:0]               i_rdata_q, i_rdata_d;
  logic [31:0]               d_rdata_q, d_rdata_d;
  logic                      pick_data;

  // Byte-offset and out-of-range address bits are deliberately dropped (word address wraps).
  logic unused_addr;
  assign unused_addr = ^{i_addr[31:MEM_WORDS_LOG2+2], i_addr[1:0],
                         d_addr[31:MEM_WORDS_LOG2+2], d_addr[1:0]};

`ifdef ARB_ROUND_ROBIN_EN
  logic last_data_q, last_data_d;
  assign pick_data = d_req & (~i_req | ~last_data_q);
`else
  assign pick_data = d_req;
`endif

  always_comb begin
    state_d    = state_q;
    gnt_data_d = gnt_data_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wmask_d    = wmask_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_data_d = last_data_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          gnt_data_d = pick_data;
          addr_d     = pick_data ? d_addr[MEM_WORDS_LOG2+1:2] : i_addr[MEM_WORDS_LOG2+1:2];
          we_d       = pick_data & d_we;
          wmask_d    = (pick_data && d_we) ? d_wmask : 4'b0000;
          wdata_d    = pick_data ? d_wdata : 32'h0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = 4'(WAIT_STATES);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!we_q) begin
            if (gnt_data_q) d_rdata_d = m_rdata;
            else            i_rdata_d = m_rdata;
          end
          state_d = RESP;
        end
      end
      RESP: begin
`ifdef ARB_ROUND_ROBIN_EN
        last_data_d = gnt_data_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      gnt_data_q <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wmask_q    <= 4'b0000;
      wdata_q    <= 32'h0;
      cnt_q      <= 4'd0;
      i_rdata_q  <= 32'h0;
      d_rdata_q  <= 32'h0;
`ifdef ARB_ROUND_ROBIN_EN
      last_data_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_data_q <= gnt_data_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wmask_q    <= wmask_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_data_q <= last_data_d;
`endif
    end
  end

  // Memory-side outputs are gated so the bus is quiet outside the single issue cycle.
  assign m_en    = (state_q == ISSUE);
  assign m_addr  = m_en ? addr_q  : '0;
  assign m_wmask = m_en ? wmask_q : 4'b0000;
  assign m_wdata = m_en ? wdata_q : 32'h0;
  assign i_ack   = (state_q == RESP) & ~gnt_data_q;
  assign d_ack   = (state_q == RESP) &  gnt_data_q;
  assign busy    = (state_q != IDLE);
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
endmodule
